// File: rtl/gated_bank_wr_sched.sv
// Write-port scheduler for a clock-gated register bank: round-robin grant onto the
// single bank write port, plus the bank ICG enable (wake on demand, gate when idle).
module gated_bank_wr_sched #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 16,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  test_en,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic [DEPTH-1:0]      wr_en,
   output logic [AW-1:0]         wr_addr,
   output logic [WIDTH-1:0]      wr_data,
   output logic                  bank_clk_en,
   output logic                  addr_err,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {GATED = 2'd0, WAKE = 2'd1, ACTIVE = 2'd2} state_t;

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WCW = $clog2(WAKE_CYCLES + 1);
   localparam int ICW = $clog2(IDLE_CYCLES + 1);

   state_t                     state_q, state_d;
   logic [PW-1:0]              ptr_q, ptr_d;
   logic [WCW-1:0]             wake_cnt_q, wake_cnt_d;
   logic [ICW-1:0]             idle_cnt_q, idle_cnt_d;
   logic                       clk_en_q;
   logic [NREQ-1:0][AW-1:0]    addr_v;
   logic [NREQ-1:0][WIDTH-1:0] data_v;
   logic                       gnt_any;
   logic [PW-1:0]              gnt_idx;
   logic [AW-1:0]              g_addr;
   logic [WIDTH-1:0]           g_data;
   logic [DEPTH-1:0]           onehot;
   logic                       addr_bad;
   logic                       idle;

   assign addr_v = req_addr;
   assign data_v = req_data;

   // Rotating priority: first requester at or above ptr, wrapping.
   always_comb begin : rr_pick
      logic [PW-1:0] idx;
      idx     = '0;
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_any && state_q == ACTIVE && req[idx]) begin
            gnt_any      = 1'b1;
            gnt_idx      = idx;
            gnt[idx]     = 1'b1;
         end
      end
   end

   assign g_addr = addr_v[gnt_idx];
   assign g_data = data_v[gnt_idx];
   assign onehot = DEPTH'(1) << g_addr;

   // Out-of-range addresses only exist when DEPTH is not a power of two.
   generate
      if ((1 << AW) > DEPTH) begin : g_chk
         assign addr_bad = ({1'b0, g_addr} >= (AW+1)'(DEPTH));
      end else begin : g_nochk
         assign addr_bad = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      ptr_d      = ptr_q;
      idle       = (req == '0) && (wr_en == '0);
      case (state_q)
         GATED: begin
            if (|req) state_d = WAKE;
         end
         WAKE: begin
            if (wake_cnt_q == WCW'(WAKE_CYCLES - 1)) begin
               state_d    = ACTIVE;
               wake_cnt_d = '0;
            end else begin
               wake_cnt_d = wake_cnt_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            // A pending write in flight keeps the bank awake until it lands.
            if (!idle) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == ICW'(IDLE_CYCLES - 1)) begin
               state_d    = GATED;
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         default: state_d = GATED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= GATED;
         ptr_q      <= '0;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
         clk_en_q   <= 1'b0;
         wr_en      <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         addr_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         clk_en_q   <= (state_d != GATED);
         wr_en      <= (gnt_any && !addr_bad) ? onehot : '0;
         addr_err   <= gnt_any && addr_bad;
         if (gnt_any) begin
            wr_addr <= g_addr;
            wr_data <= g_data;
         end
      end
   end

   // Flop output ORed with a static DFT term only, so the ICG enable cannot glitch.
   assign bank_clk_en = clk_en_q | test_en;
   assign state       = state_q;

endmodule

// File: tb/tb_gated_bank_wr_sched.sv
// Bench for gated_bank_wr_sched: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the scheduling and gating rules.
module tb_gated_bank_wr_sched;
   localparam int NREQ = 4, WIDTH = 32, DEPTH = 12, AW = $clog2(DEPTH);
   localparam int IDLE = 8, WAKE = 2;

   logic clk = 1'b0, rst_n = 1'b0, test_en = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*AW-1:0]    req_addr = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       gnt;
   logic [DEPTH-1:0]      wr_en;
   logic [AW-1:0]         wr_addr;
   logic [WIDTH-1:0]      wr_data;
   logic                  bank_clk_en, addr_err;
   logic [1:0]            state;

   int total = 0, bad = 0;

   // model: phase 0 asleep, 1 waking, 2 on
   int               m_phase, m_wake, m_quiet, m_rr;
   logic [DEPTH-1:0] m_wr_en;
   logic [AW-1:0]    m_wr_addr;
   logic [WIDTH-1:0] m_wr_data;
   logic             m_err;

   gated_bank_wr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
                         .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
      .clk(clk), .rst_n(rst_n), .test_en(test_en), .req(req), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .bank_clk_en(bank_clk_en), .addr_err(addr_err), .state(state));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_phase = 0; m_wake = 0; m_quiet = 0; m_rr = 0;
      m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0; m_err = 1'b0;
   endtask

   function automatic logic [NREQ-1:0] exp_gnt();
      logic [NREQ-1:0] g;
      g = '0;
      if (m_phase == 2 && req != '0)
         for (int k = NREQ - 1; k >= 0; k--)
            if (req[(m_rr + k) % NREQ]) begin g = '0; g[(m_rr + k) % NREQ] = 1'b1; end
      return g;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*WIDTH +: WIDTH] = d;
   endtask

   // Advance one clock; the model takes the same edge using the inputs held now.
   task automatic tick();
      logic [NREQ-1:0] g;
      int gi, n_phase, n_wake, n_quiet, n_rr;
      logic [DEPTH-1:0] n_wr_en;
      logic [AW-1:0] n_addr, a;
      logic [WIDTH-1:0] n_data;
      logic n_err;
      g = exp_gnt(); gi = -1;
      for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
      n_phase = m_phase; n_wake = m_wake; n_quiet = m_quiet; n_rr = m_rr;
      n_addr = m_wr_addr; n_data = m_wr_data; n_wr_en = '0; n_err = 1'b0;
      if (gi >= 0) begin
         a = req_addr[gi*AW +: AW];
         n_addr = a; n_data = req_data[gi*WIDTH +: WIDTH];
         if (int'(a) < DEPTH) n_wr_en[a] = 1'b1; else n_err = 1'b1;
         n_rr = (gi + 1) % NREQ;
      end
      case (m_phase)
         0: if (req != '0) begin n_phase = 1; n_wake = 0; end
         1: begin
            n_wake = m_wake + 1;
            if (n_wake == WAKE) begin n_phase = 2; n_wake = 0; end
         end
         default: begin
            if (req == '0 && m_wr_en == '0) begin
               n_quiet = m_quiet + 1;
               if (n_quiet == IDLE) begin n_phase = 0; n_quiet = 0; end
            end else n_quiet = 0;
         end
      endcase
      @(posedge clk); #1;
      if (!rst_n) model_reset();
      else begin
         m_phase = n_phase; m_wake = n_wake; m_quiet = n_quiet; m_rr = n_rr;
         m_wr_en = n_wr_en; m_wr_addr = n_addr; m_wr_data = n_data; m_err = n_err;
      end
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (gnt != '0) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      req = '1; #1;
      total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
      total++; if (gnt !== '0) begin bad++; $display("FAIL rst_gnt got=%b want=0", gnt); end
      total++; if (wr_en !== '0 || addr_err !== 1'b0) begin bad++; $display("FAIL rst_wr got=%h/%b want=0/0", wr_en, addr_err); end
      total++; if (wr_addr !== '0 || wr_data !== '0) begin bad++; $display("FAIL rst_addr_data got=%h/%h want=0/0", wr_addr, wr_data); end
      total++; if (bank_clk_en !== 1'b0) begin bad++; $display("FAIL rst_clk_en got=%b want=0", bank_clk_en); end
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_hold_state got=%0d want=0", state); end
      req = '0; rst_n = 1'b1; #1;
   endtask

   task automatic test_wake();
      set_req(2, 4'd5, 32'hA5A5A5A5); #1;
      total++; if (bank_clk_en !== 1'b0) begin bad++; $display("FAIL wake_c0_clk_en got=%b want=0", bank_clk_en); end
      tick();
      total++; if (bank_clk_en !== 1'b1 || state !== 2'd1) begin bad++; $display("FAIL wake_c1 got=%b/%0d want=1/1", bank_clk_en, state); end
      tick();
      total++; if (gnt !== '0) begin bad++; $display("FAIL wake_c2_gnt got=%b want=0000", gnt); end
      tick();
      total++; if (gnt !== 4'b0100 || state !== 2'd2) begin bad++; $display("FAIL wake_c3_gnt got=%b/%0d want=0100/2", gnt, state); end
      tick(); req = '0; #1;
      total++; if (wr_en !== 12'h020) begin bad++; $display("FAIL wake_c4_wr_en got=%h want=020", wr_en); end
      total++; if (wr_data !== 32'hA5A5A5A5 || wr_addr !== 4'd5) begin bad++; $display("FAIL wake_c4_wr got=%h/%h want=a5a5a5a5/5", wr_data, wr_addr); end
   endtask

   task automatic test_idle_gating();
      bit ok;
      for (int c = 1; c <= IDLE; c++) begin
         tick();
         total++; if (bank_clk_en !== 1'b1 || state !== 2'd2) begin bad++; $display("FAIL idle_hold c=%0d got=%b/%0d want=1/2", c, bank_clk_en, state); end
      end
      tick();
      total++; if (bank_clk_en !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL idle_gate got=%b/%0d want=0/0", bank_clk_en, state); end
      set_req(0, 4'd1, 32'h1111_0000); #1;
      wait_gnt(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL idle_regrant got=timeout want=grant"); end
      tick(); req = '0; #1;
      total++; if (wr_en !== 12'h002) begin bad++; $display("FAIL idle_wr got=%h want=002", wr_en); end
      repeat (IDLE - 1) tick();
      tick(); set_req(3, 4'd3, 32'h3333_3333); #1;
      total++; if (gnt !== 4'b1000 || state !== 2'd2) begin bad++; $display("FAIL idle_late_req got=%b/%0d want=1000/2", gnt, state); end
      tick(); req = '0; #1;
      total++; if (state !== 2'd2 || wr_en !== 12'h008 || bank_clk_en !== 1'b1) begin bad++; $display("FAIL idle_late_wr got=%0d/%h/%b want=2/008/1", state, wr_en, bank_clk_en); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] seq1 [5];
      logic [NREQ-1:0] seq2 [4];
      seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq2 = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 4), 32'hC0DE_0000 + i);
      #1;
      for (int k = 0; k < 5; k++) begin
         total++; if (gnt !== seq1[k]) begin bad++; $display("FAIL rr_all k=%0d got=%b want=%b", k, gnt, seq1[k]); end
         tick();
      end
      req[1] = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         total++; if (gnt !== seq2[k]) begin bad++; $display("FAIL rr_skip k=%0d got=%b want=%b", k, gnt, seq2[k]); end
         tick();
      end
      req = '0;
   endtask

   task automatic test_addr_err();
      req = '0; set_req(1, 4'd13, 32'hDEAD_BEEF); #1;
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL aerr_gnt got=%b want=0010", gnt); end
      tick(); req = '0; #1;
      total++; if (wr_en !== '0 || addr_err !== 1'b1 || wr_addr !== 4'd13) begin bad++; $display("FAIL aerr_pulse got=%h/%b/%0d want=0/1/13", wr_en, addr_err, wr_addr); end
      tick();
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL aerr_width got=%b want=0", addr_err); end
      set_req(1, 4'd2, 32'h0); set_req(2, 4'd3, 32'h0); #1;
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL aerr_ptr got=%b want=0100", gnt); end
      tick(); req = '0;
   endtask

   task automatic test_test_en();
      req = '0;
      repeat (IDLE + 4) tick();
      total++; if (state !== 2'd0 || bank_clk_en !== 1'b0) begin bad++; $display("FAIL ten_pre got=%0d/%b want=0/0", state, bank_clk_en); end
      test_en = 1'b1; #1;
      total++; if (bank_clk_en !== 1'b1) begin bad++; $display("FAIL ten_force got=%b want=1", bank_clk_en); end
      repeat (3) tick();
      total++; if (state !== 2'd0 || gnt !== '0 || bank_clk_en !== 1'b1) begin bad++; $display("FAIL ten_hold got=%0d/%b/%b want=0/0000/1", state, gnt, bank_clk_en); end
      test_en = 1'b0; #1;
      total++; if (bank_clk_en !== 1'b0) begin bad++; $display("FAIL ten_drop got=%b want=0", bank_clk_en); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      set_req(0, 4'd2, 32'h2222_2222); #1;
      wait_gnt(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL mrst_grant got=timeout want=grant"); end
      tick(); req = '0; #1;
      total++; if (wr_en !== 12'h004) begin bad++; $display("FAIL mrst_wr got=%h want=004", wr_en); end
      #2; rst_n = 1'b0; #1; model_reset();
      total++; if (wr_en !== '0 || state !== 2'd0 || bank_clk_en !== 1'b0) begin bad++; $display("FAIL mrst_async got=%h/%0d/%b want=0/0/0", wr_en, state, bank_clk_en); end
      test_en = 1'b1; #1;
      total++; if (bank_clk_en !== 1'b1) begin bad++; $display("FAIL mrst_ten got=%b want=1", bank_clk_en); end
      test_en = 1'b0;
      tick(); rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 32'h0);
      #1;
      wait_gnt(ok);
      total++; if (ok !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL mrst_first got=%b want=0001", gnt); end
      tick(); req = '0;
   endtask

   task automatic test_random();
      int seg = 0;
      bit busy = 1'b0;
      logic [NREQ-1:0] eg;
      for (int c = 0; c < 400; c++) begin
         if (seg == 0) begin seg = $urandom_range(1, 14); busy = ($urandom_range(0, 2) != 0); end
         seg--;
         req = busy ? NREQ'($urandom) : '0;
         for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            req_data[i*WIDTH +: WIDTH] = $urandom;
         end
         test_en = ($urandom_range(0, 15) == 0);
         #1;
         eg = exp_gnt();
         total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, eg); end
         total++; if (wr_en !== m_wr_en || addr_err !== m_err) begin bad++; $display("FAIL rnd_wr c=%0d got=%h/%b want=%h/%b", c, wr_en, addr_err, m_wr_en, m_err); end
         total++; if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin bad++; $display("FAIL rnd_ad c=%0d got=%h/%h want=%h/%h", c, wr_addr, wr_data, m_wr_addr, m_wr_data); end
         total++; if (state !== 2'(m_phase)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, state, m_phase); end
         total++; if (bank_clk_en !== ((m_phase != 0) | test_en)) begin bad++; $display("FAIL rnd_clk_en c=%0d got=%b want=%b", c, bank_clk_en, (m_phase != 0) | test_en); end
         tick();
      end
      req = '0; test_en = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_wake();
      test_idle_gating();
      test_round_robin();
      test_addr_err();
      test_test_en();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
